// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, multiplier FSM states
// and datapath defaults.
package ex_pkg;

    localparam int EX_DW      = 32;
    localparam int EX_MUL_CYC = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_MUL  = 4'd12;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative radix-2 shift-add multiplier, one operand bit per cycle.
//   state    | meaning
//   MUL_IDLE | waiting; start captures operands and raises busy at once
//   MUL_RUN  | one shift-add step per cycle, busy high
//   MUL_DONE | product valid for one cycle, busy low
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int DW      = EX_DW,
    parameter int MUL_CYC = EX_MUL_CYC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] product_o
);

    localparam int CNT_W = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    a_q, a_d, b_q, b_d, prod_q, prod_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (start_i) begin
                    busy_o  = 1'b1;
                    a_d     = a_i;
                    b_d     = b_i;
                    cnt_d   = '0;
                    prod_d  = '0;
                    state_d = MUL_RUN;
                end
            end
            MUL_RUN: begin
                busy_o = 1'b1;
                if (b_q[0]) begin
                    prod_d = prod_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MUL_CYC - 1)) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                // ID/EX advances on this edge, so IDLE never sees the same MUL again
                done_o  = 1'b1;
                state_d = MUL_IDLE;
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    assign product_o = prod_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, immediate extension, ALU and multiplier.
// EX_FAST_MUL_EN selects a combinational multiply instead of the iterative unit.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DW      = EX_DW,
    parameter int MUL_CYC = EX_MUL_CYC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   id_immei_i,
    input  logic [4:0]    id_rs_addr_i,
    input  logic [4:0]    id_rt_addr_i,
    input  logic [4:0]    id_rd_addr_i,
    input  logic [DW-1:0] id_rs_data_i,
    input  logic [DW-1:0] id_rt_data_i,
    input  logic          id_rt_imme_sel_i,
    input  logic [3:0]    id_alu_sel_i,
    input  logic          id_mem_en_i,
    input  logic          id_wb_reg_en_i,
    input  logic          id_wb_sel_i,
    input  logic          id_mem_r_i,
    input  logic          mem_fwd_en_i,
    input  logic [4:0]    mem_fwd_addr_i,
    input  logic [DW-1:0] mem_fwd_data_i,
    input  logic          wb_fwd_en_i,
    input  logic [4:0]    wb_fwd_addr_i,
    input  logic [DW-1:0] wb_fwd_data_i,
    output logic [DW-1:0] ex_alu_result_o,
    output logic [DW-1:0] ex_store_data_o,
    output logic [4:0]    ex_wb_addr_o,
    output logic          ex_mem_en_o,
    output logic          ex_wb_reg_en_o,
    output logic          ex_wb_sel_o,
    output logic          ex_mem_r_o,
    output logic          stall_o
);

    logic [DW-1:0] rs_fwd, rt_fwd, imm_ext, opa, opb, alu_res, mul_res;
    logic [4:0]    shamt;
    logic          mul_busy;

    function automatic logic [DW-1:0] fwd_sel(input logic [4:0] addr, input logic [DW-1:0] rf);
        if (mem_fwd_en_i && addr != 5'd0 && addr == mem_fwd_addr_i) return mem_fwd_data_i;
        if (wb_fwd_en_i && addr != 5'd0 && addr == wb_fwd_addr_i) return wb_fwd_data_i;
        return rf;
    endfunction

    assign rs_fwd = fwd_sel(id_rs_addr_i, id_rs_data_i);
    assign rt_fwd = fwd_sel(id_rt_addr_i, id_rt_data_i);
    assign shamt  = id_immei_i[10:6];

    // Logical ops take the immediate unsigned, everything else signed
    assign imm_ext = (id_alu_sel_i == ALU_AND || id_alu_sel_i == ALU_OR || id_alu_sel_i == ALU_XOR)
                   ? DW'(id_immei_i) : DW'($signed(id_immei_i));
    assign opa = rs_fwd;
    assign opb = id_rt_imme_sel_i ? imm_ext : rt_fwd;

`ifdef EX_FAST_MUL_EN
    assign mul_res  = opa * opb;
    assign mul_busy = 1'b0;
`else
    logic          mul_start, mul_done;
    logic [DW-1:0] mul_prod;

    assign mul_start = (id_alu_sel_i == ALU_MUL) && id_wb_reg_en_i;

    ex_mul_iter #(.DW(DW), .MUL_CYC(MUL_CYC)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (opa),
        .b_i       (opb),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    assign mul_res = mul_done ? mul_prod : '0;
`endif

    always_comb begin
        alu_res = '0;
        case (id_alu_sel_i)
            ALU_ADD:  alu_res = opa + opb;
            ALU_SUB:  alu_res = opa - opb;
            ALU_AND:  alu_res = opa & opb;
            ALU_OR:   alu_res = opa | opb;
            ALU_XOR:  alu_res = opa ^ opb;
            ALU_NOR:  alu_res = ~(opa | opb);
            ALU_SLT:  alu_res = DW'($signed(opa) < $signed(opb));
            ALU_SLTU: alu_res = DW'(opa < opb);
            ALU_SLL:  alu_res = opb << shamt;
            ALU_SRL:  alu_res = opb >> shamt;
            ALU_SRA:  alu_res = $signed(opb) >>> shamt;
            ALU_LUI:  alu_res = DW'({id_immei_i, 16'b0});
            ALU_MUL:  alu_res = mul_res;
            default:  alu_res = '0;
        endcase
    end

    // Reset and multiplier stall both present an all-zero bubble downstream
    always_comb begin
        ex_alu_result_o = alu_res;
        ex_store_data_o = rt_fwd;
        ex_wb_addr_o    = id_rt_imme_sel_i ? id_rt_addr_i : id_rd_addr_i;
        ex_mem_en_o     = id_mem_en_i;
        ex_wb_reg_en_o  = id_wb_reg_en_i;
        ex_wb_sel_o     = id_wb_sel_i;
        ex_mem_r_o      = id_mem_r_i;
        stall_o         = rst & mul_busy;
        if (!rst || mul_busy) begin
            ex_alu_result_o = '0;
            ex_store_data_o = '0;
            ex_wb_addr_o    = '0;
            ex_mem_en_o     = 1'b0;
            ex_wb_reg_en_o  = 1'b0;
            ex_wb_sel_o     = 1'b0;
            ex_mem_r_o      = 1'b0;
        end
    end

endmodule
